// File: rtl/sm_fixed_pkg.sv
// Shared definitions for the sign-magnitude fixed-point datapath.
// Used by twos_to_sm_fixed, sm_align_sat, add_fixed and the butterflies.
//   SM_N / SM_Q    : default word width and fractional bits (Q11 in 20 bits)
//   SM_SAT_INT     : largest integer part a word may carry (255 at defaults)
//   SM_MAG_MAX     : widest magnitude sm_negzero_fix accepts (zero-extended)
//   sm_negzero_fix : returns the sign to emit, cleared when the magnitude is 0
package sm_fixed_pkg;

  localparam int SM_N       = 20;
  localparam int SM_Q       = 11;
  localparam int SM_SAT_INT = (1 << (SM_N - 1 - SM_Q)) - 1;
  localparam int SM_MAG_MAX = 64;

  // Sign-magnitude has two zeros; only +0 is ever produced.
  function automatic logic sm_negzero_fix(input logic sign,
                                          input logic [SM_MAG_MAX-1:0] mag);
    return sign && (mag != '0);
  endfunction

endpackage

// File: rtl/sm_align_sat.sv
// Combinational align / optional round / saturate for a sign-magnitude word.
// Takes an unsigned magnitude with IN_Q fractional bits and produces an
// N-bit sign-magnitude word with Q fractional bits.
// Optional feature macro: TWOS_TO_SM_ROUND_EN (round half-up before the
// shift); when undefined the magnitude is truncated (round toward zero).
// Ports:
//   sign : sign of the value (1 = negative)
//   mag  : IN_W-bit unsigned magnitude, IN_Q fractional bits
//   data : {sign, magnitude} with Q fractional bits, never negative zero
//   sat  : the magnitude was clamped to the largest integer value
module sm_align_sat
  import sm_fixed_pkg::*;
#(
  parameter int IN_W = 24,
  parameter int IN_Q = 15,
  parameter int N    = SM_N,
  parameter int Q    = SM_Q
) (
  input  logic            sign,
  input  logic [IN_W-1:0] mag,
  output logic [N-1:0]    data,
  output logic            sat
);

  localparam int SH = IN_Q - Q;
  localparam logic [IN_W-Q-1:0] SAT_INT = (IN_W-Q)'((1 << (N - 1 - Q)) - 1);
  localparam logic [N-2:0]      SAT_MAG = (N-1)'(((1 << (N - 1 - Q)) - 1) << Q);

  logic [IN_W-1:0] m;
  logic [N-2:0]    mag_out;

`ifdef TWOS_TO_SM_ROUND_EN
  if (SH > 0) begin : g_round
    // One extra bit so that rounding -2^(IN_W-1) up cannot wrap.
    localparam logic [IN_W:0] HALF = (IN_W+1)'(1) << (SH - 1);
    assign m = IN_W'(({1'b0, mag} + HALF) >> SH);
  end else begin : g_no_round
    assign m = mag;
  end
`else
  assign m = mag >> SH;
`endif

  // Anything whose integer part reaches the top integer value clamps to
  // exactly that value with zero fraction, the same rule add_fixed uses.
  assign sat     = (m[IN_W-1:Q] >= SAT_INT);
  assign mag_out = sat ? SAT_MAG : m[N-2:0];
  assign data    = {sm_negzero_fix(sign, SM_MAG_MAX'(mag_out)), mag_out};

endmodule

// File: rtl/twos_to_sm_fixed.sv
// Streaming two's-complement to sign-magnitude converter (FFT front end).
// Two pipeline stages: stage 1 takes sign and absolute value, stage 2
// aligns, optionally rounds, saturates and removes negative zero.
// Optional feature macro: TWOS_TO_SM_ROUND_EN (round half-up instead of
// truncation); latency is the same in both builds.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : in_data carries a sample
//   in_ready  : converter takes a sample this cycle (combinational)
//   in_data   : IN_W-bit two's-complement sample, IN_Q fractional bits
//   out_valid : out_data/out_sat carry a converted word
//   out_ready : downstream takes the word this cycle
//   out_data  : N-bit sign-magnitude word, Q fractional bits
//   out_sat   : the word was clamped (qualified by out_valid)
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high. Once out_valid is high, out_data and out_sat are
// held until out_ready is seen. The whole pipe advances together on
// en = !out_valid || out_ready; bubbles are kept, so at most two samples are
// ever in flight and order is preserved.
module twos_to_sm_fixed
  import sm_fixed_pkg::*;
#(
  parameter int IN_W = 24,
  parameter int IN_Q = 15,
  parameter int N    = SM_N,
  parameter int Q    = SM_Q
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_data,
  output logic            out_sat
);

  logic            en;
  logic            s1_valid;
  logic            s1_sign;
  logic [IN_W-1:0] s1_mag;
  logic [N-1:0]    s2_data;
  logic            s2_sat;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  sm_align_sat #(
    .IN_W (IN_W),
    .IN_Q (IN_Q),
    .N    (N),
    .Q    (Q)
  ) u_align (
    .sign (s1_sign),
    .mag  (s1_mag),
    .data (s2_data),
    .sat  (s2_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_mag    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_sign   <= in_data[IN_W-1];
      // Read as unsigned, the negation of -2^(IN_W-1) is 2^(IN_W-1): no wrap.
      s1_mag    <= in_data[IN_W-1] ? -in_data : in_data;
      out_valid <= s1_valid;
      out_data  <= s2_data;
      out_sat   <= s2_sat;
    end
  end

endmodule

// File: tb/tb_twos_to_sm_fixed.sv
// Self-checking bench for twos_to_sm_fixed: reset values, a table of fixed
// vectors with latency checks, backpressure and mid-stream reset sequences,
// and a long random stream compared against an arithmetic reference model.
module tb_twos_to_sm_fixed;

  localparam int IN_W = 24;
  localparam int IN_Q = 15;
  localparam int N    = 20;
  localparam int Q    = 11;

`ifdef TWOS_TO_SM_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IN_W-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [N-1:0]    out_data;
  logic            out_sat;

  always #5 clk = ~clk;

  twos_to_sm_fixed #(
    .IN_W (IN_W),
    .IN_Q (IN_Q),
    .N    (N),
    .Q    (Q)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Real-valued view: |x| scaled down by 2^(IN_Q-Q), rounded or truncated,
  // clamped at 255.0, sign kept only for nonzero results.
  // Returns {sat, sign, magnitude}.
  function automatic logic [N:0] ref_model(input logic [IN_W-1:0] x);
    longint v, a, m, lim, mag;
    longint sh;
    logic   sat, neg;
    v   = $signed(x);
    a   = (v < 0) ? -v : v;
    sh  = IN_Q - Q;
    if (RND && sh > 0) m = (a + (longint'(1) << (sh - 1))) / (longint'(1) << sh);
    else               m = a / (longint'(1) << sh);
    lim = ((longint'(1) << (N - 1 - Q)) - 1) * (longint'(1) << Q);
    sat = (m >= lim);
    mag = sat ? lim : m;
    neg = (v < 0) && (mag != 0);
    return {sat, neg, mag[N-2:0]};
  endfunction

  function automatic logic [IN_W-1:0] rand_in();
    int v;
    case ($urandom_range(0, 3))
      0:       v = int'($urandom);
      1:       v = int'($urandom_range(0, 128)) - 64;
      2:       v = (($urandom_range(0, 1) != 0) ? 1 : -1) *
                   (255 * 32768 + int'($urandom_range(0, 64)) - 32);
      default: v = int'($urandom_range(0, 1 << 20)) - (1 << 19);
    endcase
    return v[IN_W-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  // Single sample with out_ready high: not valid after one edge, valid with
  // the expected word after exactly two.
  task automatic apply_one(input logic [IN_W-1:0] d, input logic [N-1:0] exp_d,
                           input logic exp_s, input string nm);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({nm, "_lat1_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({nm, "_lat2_valid"}, 32'(out_valid), 32'd1);
    check({nm, "_data"}, 32'(out_data), 32'(exp_d));
    check({nm, "_sat"}, 32'(out_sat), 32'(exp_s));
  endtask

  typedef struct {
    string           name;
    logic [IN_W-1:0] din;
    logic [N-1:0]    dout;
    logic            sat;
  } vec_t;

  vec_t tbl[14];

  // ---------------- scoreboard ----------------
  logic [N:0]      exp_q[$];
  logic [IN_W-1:0] src_q[$];
  logic [N-1:0]    got_q[$];

  initial begin
    logic [N:0]   e;
    logic         hold_prev;
    logic [N:0]   prev_word;
    int           cyc;

    tbl[0]  = '{"one",        24'h008000, 20'h00800, 1'b0};
    tbl[1]  = '{"minus_one",  24'hFF8000, 20'h80800, 1'b0};
    tbl[2]  = '{"max_pos",    24'h7FFFFF, 20'h7F800, 1'b1};
    tbl[3]  = '{"min_neg",    24'h800000, 20'hFF800, 1'b1};
    tbl[4]  = '{"p255",       24'h7F8000, 20'h7F800, 1'b1};
    tbl[5]  = '{"m255",       24'h808000, 20'hFF800, 1'b1};
    tbl[6]  = '{"m_half_lsb", 24'hFFFFF8, RND ? 20'h80001 : 20'h00000, 1'b0};
    tbl[7]  = '{"m_one_lsb",  24'hFFFFFF, 20'h00000, 1'b0};
    tbl[8]  = '{"zero",       24'h000000, 20'h00000, 1'b0};
    tbl[9]  = '{"p_one_lsb",  24'h000001, 20'h00000, 1'b0};
    tbl[10] = '{"p_half_lsb", 24'h000008, RND ? 20'h00001 : 20'h00000, 1'b0};
    tbl[11] = '{"below_255",  24'h7F7FFF, RND ? 20'h7F800 : 20'h7F7FF, RND};
    tbl[12] = '{"m_1p5",      24'hFF4000, 20'h80C00, 1'b0};
    tbl[13] = '{"p_2p25",     24'h012000, 20'h01200, 1'b0};

    // ---- reset state ----
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);

    // ---- table vectors ----
    for (int i = 0; i < 14; i++) apply_one(tbl[i].din, tbl[i].dout, tbl[i].sat, tbl[i].name);

    // ---- backpressure ----
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 24'h000010;
    @(posedge clk);
    @(negedge clk);
    check("bp_ready_before_valid", 32'(in_ready), 32'd1);
    in_data = 24'h000020;
    @(posedge clk);
    @(negedge clk);
    in_data = 24'h000030;
    for (int i = 0; i < 3; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_data", 32'(out_data), 32'h00001);
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    got_q.delete();
    for (int i = 0; i < 6; i++) begin
      if (out_valid) got_q.push_back(out_data);
      @(posedge clk);
      @(negedge clk);
      if (i == 0) in_valid = 1'b0;
    end
    check("bp_count", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check("bp_order", (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(i + 1));

    // ---- reset mid-stream ----
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 24'h008000;
    @(posedge clk);
    @(negedge clk);
    in_data = 24'hFF8000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid0", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid1", 32'(out_valid), 32'd0);
    apply_one(24'h010000, 20'h01000, 1'b0, "post_rst");

    // ---- random stream ----
    src_q.delete();
    src_q.push_back(24'h000000);
    src_q.push_back(24'h000001);
    src_q.push_back(24'hFFFFFF);
    src_q.push_back(24'h000008);
    src_q.push_back(24'hFFFFF8);
    src_q.push_back(24'h7F8000);
    src_q.push_back(24'h808000);
    src_q.push_back(24'h800000);
    for (int i = 0; i < 10000; i++) src_q.push_back(rand_in());
    exp_q.delete();
    hold_prev = 1'b0;
    prev_word = '0;
    cyc       = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && cyc < 80000) begin
      @(negedge clk);
      in_valid  = (src_q.size() > 0) && ($urandom_range(0, 3) != 0);
      in_data   = (src_q.size() > 0) ? src_q[0] : '0;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (hold_prev) check("rand_hold_word", 32'({out_sat, out_data}), 32'(prev_word));
      if (out_valid && !out_ready) check("rand_hold_in_ready", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_spurious_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rand_data", 32'(out_data), 32'(e[N-1:0]));
          check("rand_sat", 32'(out_sat), 32'(e[N]));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_model(src_q.pop_front()));
      hold_prev = out_valid && !out_ready;
      prev_word = {out_sat, out_data};
      cyc++;
    end
    check("rand_within_budget", 32'(cyc < 80000), 32'd1);
    check("rand_all_drained", 32'(exp_q.size()), 32'd0);

    // ---- final report ----
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
